// File: rtl/lsu.sv
// Load/store unit: takes one EXU memory request at a time, performs it on a
// word-aligned valid/ready data bus, and returns extended load data with an
// error flag on a one-cycle respValid pulse.
module lsu #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        reqValid,
    output logic        respValid,
    input  logic        lsu_ren,
    input  logic        lsu_wen,
    input  logic [1:0]  lsu_size,
    input  logic        lsu_unsigned,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_wdata,
    output logic [31:0] lsu_rdata,
    output logic        lsu_err,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_rdata,
    input  logic        mem_resp_err
);

    localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    state_t      state;
    logic [7:0]  cnt;
    logic [1:0]  q_size;
    logic        q_unsigned;
    logic [1:0]  q_off;

    logic        illegal;
    logic [3:0]  strb_base;
    logic [3:0]  strb;
    logic [31:0] wdata_shift;
    logic [31:0] rd_shift;
    logic [31:0] load_ext;

    // Decode the incoming request: legality, byte-lane strobes and store data steering
    always_comb begin
        illegal   = 1'b0;
        strb_base = 4'b1111;
        if (lsu_ren && lsu_wen) illegal = 1'b1;
        case (lsu_size)
            2'b00: strb_base = 4'b0001;
            2'b01: begin
                strb_base = 4'b0011;
                if (lsu_addr[0]) illegal = 1'b1;
            end
            2'b10: begin
                strb_base = 4'b1111;
                if (lsu_addr[1:0] != 2'b00) illegal = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
        strb        = lsu_wen ? (strb_base << lsu_addr[1:0]) : 4'b0000;
        wdata_shift = lsu_wdata << {lsu_addr[1:0], 3'b000};
    end

    // Extract the addressed byte/half/word from the bus word and extend it
    always_comb begin
        rd_shift = mem_rdata >> {q_off, 3'b000};
        load_ext = rd_shift;
        case (q_size)
            2'b00:   load_ext = q_unsigned ? {24'h0, rd_shift[7:0]}
                                           : {{24{rd_shift[7]}}, rd_shift[7:0]};
            2'b01:   load_ext = q_unsigned ? {16'h0, rd_shift[15:0]}
                                           : {{16{rd_shift[15]}}, rd_shift[15:0]};
            default: load_ext = rd_shift;
        endcase
    end

    // Request FSM with registered bus and response outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            cnt           <= '0;
            q_size        <= '0;
            q_unsigned    <= 1'b0;
            q_off         <= '0;
            respValid     <= 1'b0;
            lsu_rdata     <= '0;
            lsu_err       <= 1'b0;
            mem_req_valid <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_wstrb     <= '0;
        end else begin
            respValid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (reqValid) begin
                        if (!lsu_ren && !lsu_wen) begin
                            state     <= S_DONE;
                            respValid <= 1'b1;
                            lsu_err   <= 1'b0;
                            lsu_rdata <= '0;
                        end else if (illegal) begin
                            state     <= S_DONE;
                            respValid <= 1'b1;
                            lsu_err   <= 1'b1;
                            lsu_rdata <= '0;
                        end else begin
                            state         <= S_REQ;
                            q_size        <= lsu_size;
                            q_unsigned    <= lsu_unsigned;
                            q_off         <= lsu_addr[1:0];
                            mem_req_valid <= 1'b1;
                            mem_we        <= lsu_wen;
                            mem_addr      <= {lsu_addr[31:2], 2'b00};
                            mem_wdata     <= wdata_shift;
                            mem_wstrb     <= strb;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        cnt           <= '0;
                        state         <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_resp_valid) begin
                        state     <= S_DONE;
                        respValid <= 1'b1;
                        lsu_err   <= mem_resp_err;
                        lsu_rdata <= (mem_resp_err || mem_we) ? '0 : load_ext;
                    end else if (cnt == TO_CNT) begin
                        state     <= S_DONE;
                        respValid <= 1'b1;
                        lsu_err   <= 1'b1;
                        lsu_rdata <= '0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Directed self-checking bench for lsu: aligned/unaligned loads and stores,
// illegal requests, bus error, timeout, stray responses and reset mid-operation.
module tb_lsu;

    localparam int unsigned TO = 20;

    logic        clock = 1'b0;
    logic        reset;
    logic        reqValid;
    logic        respValid;
    logic        lsu_ren;
    logic        lsu_wen;
    logic [1:0]  lsu_size;
    logic        lsu_unsigned;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic [31:0] lsu_rdata;
    logic        lsu_err;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_resp_valid;
    logic [31:0] mem_rdata;
    logic        mem_resp_err;

    int checks = 0;
    int errors = 0;

    lsu #(.TIMEOUT(TO)) dut (
        .clock          (clock),
        .reset          (reset),
        .reqValid       (reqValid),
        .respValid      (respValid),
        .lsu_ren        (lsu_ren),
        .lsu_wen        (lsu_wen),
        .lsu_size       (lsu_size),
        .lsu_unsigned   (lsu_unsigned),
        .lsu_addr       (lsu_addr),
        .lsu_wdata      (lsu_wdata),
        .lsu_rdata      (lsu_rdata),
        .lsu_err        (lsu_err),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_wstrb      (mem_wstrb),
        .mem_resp_valid (mem_resp_valid),
        .mem_rdata      (mem_rdata),
        .mem_resp_err   (mem_resp_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input logic ren, input logic wen, input logic [1:0] size,
                           input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
        lsu_ren      = ren;
        lsu_wen      = wen;
        lsu_size     = size;
        lsu_unsigned = uns;
        lsu_addr     = addr;
        lsu_wdata    = wdata;
        reqValid     = 1'b1;
    endtask

    // Full memory operation with immediate ready and response: respValid on the 3rd edge
    task automatic do_op(input string tag, input logic ren, input logic wen, input logic [1:0] size,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] bus_rdata, input logic bus_err,
                         input logic [31:0] e_addr, input logic e_we, input logic [3:0] e_strb,
                         input logic [31:0] e_wdata, input logic [31:0] e_rdata, input logic e_err);
        set_req(ren, wen, size, uns, addr, wdata);
        tick();
        check({tag, "_reqv"},  32'(mem_req_valid), 32'd1);
        check({tag, "_addr"},  mem_addr, e_addr);
        check({tag, "_we"},    32'(mem_we), 32'(e_we));
        check({tag, "_strb"},  32'(mem_wstrb), 32'(e_strb));
        if (e_we) check({tag, "_wdata"}, mem_wdata, e_wdata);
        check({tag, "_resp1"}, 32'(respValid), 32'd0);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready  = 1'b0;
        check({tag, "_reqv2"}, 32'(mem_req_valid), 32'd0);
        check({tag, "_resp2"}, 32'(respValid), 32'd0);
        mem_resp_valid = 1'b1;
        mem_rdata      = bus_rdata;
        mem_resp_err   = bus_err;
        tick();
        mem_resp_valid = 1'b0;
        mem_resp_err   = 1'b0;
        reqValid       = 1'b0;
        check({tag, "_resp3"}, 32'(respValid), 32'd1);
        check({tag, "_rdata"}, lsu_rdata, e_rdata);
        check({tag, "_err"},   32'(lsu_err), 32'(e_err));
        tick();
        check({tag, "_resp4"}, 32'(respValid), 32'd0);
    endtask

    // Non-memory or illegal request: respValid on the first edge, no bus activity
    task automatic do_quick(input string tag, input logic ren, input logic wen, input logic [1:0] size,
                            input logic [31:0] addr, input logic e_err);
        set_req(ren, wen, size, 1'b0, addr, 32'h0);
        tick();
        reqValid = 1'b0;
        check({tag, "_resp"},  32'(respValid), 32'd1);
        check({tag, "_reqv"},  32'(mem_req_valid), 32'd0);
        check({tag, "_err"},   32'(lsu_err), 32'(e_err));
        check({tag, "_rdata"}, lsu_rdata, 32'h0);
        tick();
        check({tag, "_resp2"}, 32'(respValid), 32'd0);
        check({tag, "_reqv2"}, 32'(mem_req_valid), 32'd0);
    endtask

    initial begin
        int n;
        reset = 1'b1;
        reqValid = 1'b0; lsu_ren = 1'b0; lsu_wen = 1'b0; lsu_size = 2'b00;
        lsu_unsigned = 1'b0; lsu_addr = '0; lsu_wdata = '0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0; mem_resp_err = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_resp",  32'(respValid), 32'd0);
        check("rst_reqv",  32'(mem_req_valid), 32'd0);
        check("rst_rdata", lsu_rdata, 32'h0);
        check("rst_err",   32'(lsu_err), 32'd0);
        check("rst_strb",  32'(mem_wstrb), 32'd0);
        check("rst_addr",  mem_addr, 32'h0);
        tick();

        //      tag    ren   wen   size   uns   addr        wdata        bus_rdata     berr  e_addr      we    strb     e_wdata      e_rdata      e_err
        do_op("lb",   1'b1, 1'b0, 2'b00, 1'b0, 32'h103, 32'h0,        32'h80AA_BBCC, 1'b0, 32'h100, 1'b0, 4'b0000, 32'h0,        32'hFFFF_FF80, 1'b0);
        do_op("lhu",  1'b1, 1'b0, 2'b01, 1'b1, 32'h202, 32'h0,        32'hBEEF_1234, 1'b0, 32'h200, 1'b0, 4'b0000, 32'h0,        32'h0000_BEEF, 1'b0);
        do_op("lh",   1'b1, 1'b0, 2'b01, 1'b0, 32'h202, 32'h0,        32'hBEEF_1234, 1'b0, 32'h200, 1'b0, 4'b0000, 32'h0,        32'hFFFF_BEEF, 1'b0);
        do_op("lbu",  1'b1, 1'b0, 2'b00, 1'b1, 32'h201, 32'h0,        32'h1234_F600, 1'b0, 32'h200, 1'b0, 4'b0000, 32'h0,        32'h0000_00F6, 1'b0);
        do_op("lw",   1'b1, 1'b0, 2'b10, 1'b0, 32'h404, 32'h0,        32'hCAFE_F00D, 1'b0, 32'h404, 1'b0, 4'b0000, 32'h0,        32'hCAFE_F00D, 1'b0);
        do_op("sb",   1'b0, 1'b1, 2'b00, 1'b0, 32'h301, 32'h0000_00A5, 32'h0,        1'b0, 32'h300, 1'b1, 4'b0010, 32'h0000_A500, 32'h0,        1'b0);
        do_op("sh",   1'b0, 1'b1, 2'b01, 1'b0, 32'h102, 32'h0000_1234, 32'h0,        1'b0, 32'h100, 1'b1, 4'b1100, 32'h1234_0000, 32'h0,        1'b0);
        do_op("sw",   1'b0, 1'b1, 2'b10, 1'b0, 32'h010, 32'h89AB_CDEF, 32'hFFFF_FFFF, 1'b0, 32'h010, 1'b1, 4'b1111, 32'h89AB_CDEF, 32'h0,        1'b0);
        do_op("berr", 1'b1, 1'b0, 2'b10, 1'b0, 32'h020, 32'h0,        32'h5555_5555, 1'b1, 32'h020, 1'b0, 4'b0000, 32'h0,        32'h0,        1'b1);

        do_quick("lw_mis", 1'b1, 1'b0, 2'b10, 32'h402, 1'b1);
        do_quick("lh_mis", 1'b1, 1'b0, 2'b01, 32'h403, 1'b1);
        do_quick("sz11",   1'b1, 1'b0, 2'b11, 32'h400, 1'b1);
        do_quick("rw",     1'b1, 1'b1, 2'b10, 32'h400, 1'b1);
        do_quick("nop",    1'b0, 1'b0, 2'b10, 32'h400, 1'b0);

        // Response coinciding with ready in REQ is not taken; WAIT holds until a real one
        set_req(1'b1, 1'b0, 2'b00, 1'b1, 32'h002, 32'h0);
        tick();
        mem_req_ready = 1'b1; mem_resp_valid = 1'b1; mem_rdata = 32'h0011_2233;
        tick();
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        check("stray_req_resp", 32'(respValid), 32'd0);
        tick();
        check("stray_wait_resp", 32'(respValid), 32'd0);
        mem_resp_valid = 1'b1; mem_rdata = 32'h0077_8899;
        tick();
        mem_resp_valid = 1'b0; reqValid = 1'b0;
        check("stray_done_resp",  32'(respValid), 32'd1);
        check("stray_done_rdata", lsu_rdata, 32'h0000_0077);
        tick();

        // Ready held off for 5 cycles, then no response until timeout
        set_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h020, 32'h0);
        tick();
        for (int i = 0; i < 5; i++) begin
            check($sformatf("to_hold%0d", i), 32'(mem_req_valid), 32'd1);
            tick();
        end
        check("to_hold_resp", 32'(respValid), 32'd0);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        check("to_wait_reqv", 32'(mem_req_valid), 32'd0);
        n = 0;
        while (!respValid && n < int'(TO) + 10) begin
            tick();
            n++;
        end
        reqValid = 1'b0;
        check("to_cycles", 32'(n), 32'(TO + 1));
        check("to_resp",  32'(respValid), 32'd1);
        check("to_err",   32'(lsu_err), 32'd1);
        check("to_rdata", lsu_rdata, 32'h0);
        mem_resp_valid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        tick();
        check("late_resp1", 32'(respValid), 32'd0);
        tick();
        check("late_resp2", 32'(respValid), 32'd0);
        check("late_reqv",  32'(mem_req_valid), 32'd0);
        mem_resp_valid = 1'b0;
        do_op("after_to", 1'b1, 1'b0, 2'b00, 1'b0, 32'h001, 32'h0, 32'h0000_7F00, 1'b0,
              32'h000, 1'b0, 4'b0000, 32'h0, 32'h0000_007F, 1'b0);

        // Reset while in REQ drops the bus request without waiting for a clock
        set_req(1'b0, 1'b1, 2'b10, 1'b0, 32'h040, 32'h1111_2222);
        tick();
        check("rreq_reqv_pre", 32'(mem_req_valid), 32'd1);
        reset = 1'b1;
        #1;
        check("rreq_reqv", 32'(mem_req_valid), 32'd0);
        check("rreq_strb", 32'(mem_wstrb), 32'd0);
        reqValid = 1'b0;
        tick();
        reset = 1'b0;
        tick();

        // Give lsu_rdata a non-zero value, then reset while in WAIT
        do_op("pre_rst", 1'b1, 1'b0, 2'b10, 1'b0, 32'h080, 32'h0, 32'hA5A5_5A5A, 1'b0,
              32'h080, 1'b0, 4'b0000, 32'h0, 32'hA5A5_5A5A, 1'b0);
        set_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h0C0, 32'h0);
        tick();
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        check("rwait_addr_pre", mem_addr, 32'h0C0);
        reset = 1'b1;
        #1;
        check("rwait_rdata", lsu_rdata, 32'h0);
        check("rwait_addr",  mem_addr, 32'h0);
        check("rwait_resp",  32'(respValid), 32'd0);
        check("rwait_err",   32'(lsu_err), 32'd0);
        reqValid = 1'b0;
        mem_resp_valid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        tick();
        reset = 1'b0;
        tick();
        check("rst_idle_resp", 32'(respValid), 32'd0);
        mem_resp_valid = 1'b0;
        do_op("lw0", 1'b1, 1'b0, 2'b10, 1'b0, 32'h000, 32'h0, 32'h1234_5678, 1'b0,
              32'h000, 1'b0, 4'b0000, 32'h0, 32'h1234_5678, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
